// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory load/store port among NCORES cores.
// Optional build macro ARB_STORE_PRIORITY_EN: eligible stores win over eligible loads.
module mem_port_arbiter #(
  parameter int NCORES = 4,
  parameter int LD_LAT = 2,
  parameter int AW     = 16,
  parameter int DW     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCORES-1:0]    req_ld,
  input  logic [NCORES-1:0]    req_st,
  input  logic [NCORES*AW-1:0] req_addr,
  input  logic [NCORES*DW-1:0] req_data,
  output logic [NCORES-1:0]    gnt,
  output logic [NCORES-1:0]    rsp_valid,
  output logic [DW-1:0]        rsp_data,
  input  logic                 mem_ready,
  output logic                 mem_ld_en,
  output logic                 mem_st_en,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_st_data,
  input  logic [DW-1:0]        mem_ld_data
);

  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [NCORES-1:0] elig;
  logic [NCORES-1:0] cand;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     win;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     rr_next;
  logic [IW-1:0]     ld_own;
  logic              found;
  logic              issue;
  logic [NCORES-1:0] gnt_nx;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_data;
  logic              sel_ld;
  logic              sel_st;
  logic [LD_LAT-1:0] vld_p;
  logic [IW-1:0]     own_p [LD_LAT];

  // The core granted last cycle is masked so it cannot re-issue while it drops its request.
  assign elig = (req_ld | req_st) & ~gnt;

`ifdef ARB_STORE_PRIORITY_EN
  assign cand = (|(elig & req_st)) ? (elig & req_st) : elig;
`else
  assign cand = elig;
`endif

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NCORES; k++) begin
      idx = IW'((int'(rr_ptr) + k) % NCORES);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign issue   = found & mem_ready;
  assign rr_next = (int'(win) == NCORES - 1) ? '0 : win + IW'(1);

  always_comb begin
    gnt_nx   = '0;
    sel_addr = '0;
    sel_data = '0;
    sel_ld   = 1'b0;
    sel_st   = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      if (win == IW'(i)) begin
        gnt_nx[i] = issue;
        sel_addr  = req_addr[i*AW +: AW];
        sel_data  = req_data[i*DW +: DW];
        sel_ld    = req_ld[i];
        sel_st    = req_st[i];
      end
    end
  end

  // Issue stage: registered grant and memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= '0;
      mem_ld_en   <= 1'b0;
      mem_st_en   <= 1'b0;
      mem_addr    <= '0;
      mem_st_data <= '0;
      rr_ptr      <= '0;
      ld_own      <= '0;
    end else begin
      gnt <= gnt_nx;
      if (issue) begin
        mem_addr    <= sel_addr;
        mem_st_data <= sel_data;
        mem_st_en   <= sel_st;
        mem_ld_en   <= sel_ld & ~sel_st;
        rr_ptr      <= rr_next;
        ld_own      <= win;
      end else begin
        mem_ld_en <= 1'b0;
        mem_st_en <= 1'b0;
      end
    end
  end

  // Return stage: owner pipeline aligned with the memory's fixed load latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int i = 0; i < LD_LAT; i++) own_p[i] <= '0;
    end else begin
      vld_p[0] <= mem_ld_en;
      own_p[0] <= ld_own;
      for (int i = 1; i < LD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        own_p[i] <= own_p[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (vld_p[LD_LAT-1]) begin
      rsp_data = mem_ld_data;
      for (int i = 0; i < NCORES; i++) rsp_valid[i] = (own_p[LD_LAT-1] == IW'(i));
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected grants and
// load returns; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_port_arbiter;
  localparam int NC = 4;
  localparam int LL = 2;
  localparam int AW = 16;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NC-1:0]    req_ld, req_st;
  logic [NC*AW-1:0] req_addr;
  logic [NC*DW-1:0] req_data;
  logic [NC-1:0]    gnt, rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             mem_ready;
  logic             mem_ld_en, mem_st_en;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_st_data, mem_ld_data;
  logic [DW-1:0]    md [LL];

  typedef struct {
    int            cyc;
    logic [NC-1:0] g;
    logic          ld;
    logic          st;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } gexp_t;
  typedef struct {
    int            cyc;
    logic [NC-1:0] v;
    logic [DW-1:0] d;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bit    hold = 1'b0;

  mem_port_arbiter #(.NCORES(NC), .LD_LAT(LL), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_ld(req_ld), .req_st(req_st),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mem_ready(mem_ready),
    .mem_ld_en(mem_ld_en), .mem_st_en(mem_st_en), .mem_addr(mem_addr),
    .mem_st_data(mem_st_data), .mem_ld_data(mem_ld_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // Fixed-latency memory: idle cycles return a junk pattern.
  always @(posedge clk) begin
    md[0] <= mem_ld_en ? memval(mem_addr) : 16'hDEAD;
    for (int i = 1; i < LL; i++) md[i] <= md[i-1];
  end
  assign mem_ld_data = md[LL-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_g(input int c, input logic [NC-1:0] g, input logic ld, input logic st,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    gexp_t e;
    e.cyc = c; e.g = g; e.ld = ld; e.st = st; e.a = a; e.d = d;
    gq.push_back(e);
  endtask

  task automatic push_r(input int c, input logic [NC-1:0] v, input logic [DW-1:0] d);
    rexp_t e;
    e.cyc = c; e.v = v; e.d = d;
    rq.push_back(e);
  endtask

  task tick;
    @(posedge clk);
    #1;
    if (!hold) begin
      req_ld = req_ld & ~gnt;
      req_st = req_st & ~gnt;
    end
  endtask

  task set_core(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt != '0 || mem_ld_en || mem_st_en) begin
        n_chk++;
        if (gq.size() == 0) begin
          n_fail++;
          $display("FAIL grant_unexpected: cyc=%0d gnt=%b ld=%b st=%b addr=%h", cyc, gnt, mem_ld_en, mem_st_en, mem_addr);
        end else begin
          gexp_t e;
          e = gq.pop_front();
          if (e.cyc != cyc || e.g !== gnt || e.ld !== mem_ld_en || e.st !== mem_st_en ||
              e.a !== mem_addr || e.d !== mem_st_data) begin
            n_fail++;
            $display("FAIL grant: got cyc=%0d gnt=%b ld=%b st=%b addr=%h data=%h expected cyc=%0d gnt=%b ld=%b st=%b addr=%h data=%h",
                     cyc, gnt, mem_ld_en, mem_st_en, mem_addr, mem_st_data, e.cyc, e.g, e.ld, e.st, e.a, e.d);
          end
        end
      end
      n_chk++;
      if (rsp_valid != '0) begin
        if (rq.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: cyc=%0d rsp_valid=%b rsp_data=%h", cyc, rsp_valid, rsp_data);
        end else begin
          rexp_t e;
          e = rq.pop_front();
          if (e.cyc != cyc || e.v !== rsp_valid || e.d !== rsp_data) begin
            n_fail++;
            $display("FAIL rsp: got cyc=%0d valid=%b data=%h expected cyc=%0d valid=%b data=%h",
                     cyc, rsp_valid, rsp_data, e.cyc, e.v, e.d);
          end
        end
      end else if (rsp_data !== '0) begin
        n_fail++;
        $display("FAIL rsp_idle: cyc=%0d rsp_data=%h expected 0", cyc, rsp_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [NC-1:0] oh;
    req_ld = '0; req_st = '0; req_addr = '0; req_data = '0; mem_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_ld_en", 64'(mem_ld_en), 64'(0));
    chk("rst_st_en", 64'(mem_st_en), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    chk("rst_st_data", 64'(mem_st_data), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    rst_n = 1'b1;
    tick();

    // Single load from core 2.
    set_core(2, 16'h0010, 16'h2222);
    n = cyc; req_ld[2] = 1'b1;
    push_g(n + 1, 4'b0100, 1'b1, 1'b0, 16'h0010, 16'h2222);
    push_r(n + 1 + LL, 4'b0100, 16'hBEEF);
    repeat (6) tick();

    // Reset while a load from core 1 is in flight.
    set_core(1, 16'h0044, 16'h1111);
    n = cyc; req_ld[1] = 1'b1;
    push_g(n + 1, 4'b0010, 1'b1, 1'b0, 16'h0044, 16'h1111);
    tick(); tick();
    req_ld = '0; rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 64'(gnt), 64'(0));
    chk("midrst_ld_en", 64'(mem_ld_en), 64'(0));
    chk("midrst_addr", 64'(mem_addr), 64'(0));
    chk("midrst_rsp", 64'(rsp_valid), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("postrst_addr", 64'(mem_addr), 64'(0));

    // Fairness: all cores hold loads; rr_ptr restarts at 0 after reset.
    for (int i = 0; i < NC; i++) set_core(i, 16'(16'h0100 + i), 16'(16'h3000 + i));
    n = cyc; hold = 1'b1; req_ld = '1;
    for (int k = 0; k < 8; k++) begin
      oh = NC'(1) << (k % NC);
      push_g(n + 1 + k, oh, 1'b1, 1'b0, 16'(16'h0100 + k % NC), 16'(16'h3000 + k % NC));
      push_r(n + 1 + k + LL, oh, memval(16'(16'h0100 + k % NC)));
    end
    repeat (8) tick();
    req_ld = '0; hold = 1'b0;
    repeat (4) tick();

    // Memory stall with cores 0 and 3 requesting.
    set_core(0, 16'h0200, 16'h4000);
    set_core(3, 16'h0203, 16'h4003);
    n = cyc; mem_ready = 1'b0; req_ld = 4'b1001;
    repeat (3) tick();
    mem_ready = 1'b1;
    push_g(n + 4, 4'b0001, 1'b1, 1'b0, 16'h0200, 16'h4000);
    push_g(n + 5, 4'b1000, 1'b1, 1'b0, 16'h0203, 16'h4003);
    push_r(n + 4 + LL, 4'b0001, memval(16'h0200));
    push_r(n + 5 + LL, 4'b1000, memval(16'h0203));
    repeat (6) tick();

    // Load on core 0 competing with a store on core 1.
    set_core(0, 16'h0030, 16'h5000);
    set_core(1, 16'h0020, 16'h0007);
    n = cyc; req_ld[0] = 1'b1; req_st[1] = 1'b1;
`ifdef ARB_STORE_PRIORITY_EN
    push_g(n + 1, 4'b0010, 1'b0, 1'b1, 16'h0020, 16'h0007);
    push_g(n + 2, 4'b0001, 1'b1, 1'b0, 16'h0030, 16'h5000);
    push_r(n + 2 + LL, 4'b0001, memval(16'h0030));
`else
    push_g(n + 1, 4'b0001, 1'b1, 1'b0, 16'h0030, 16'h5000);
    push_g(n + 2, 4'b0010, 1'b0, 1'b1, 16'h0020, 16'h0007);
    push_r(n + 1 + LL, 4'b0001, memval(16'h0030));
`endif
    repeat (6) tick();

    // Core 3 raises load and store together: only the store issues.
    set_core(3, 16'h0040, 16'h1234);
    n = cyc; req_ld[3] = 1'b1; req_st[3] = 1'b1;
    push_g(n + 1, 4'b1000, 1'b0, 1'b1, 16'h0040, 16'h1234);
    repeat (6) tick();

    chk("grants_drained", 64'(gq.size()), 64'(0));
    chk("rsps_drained", 64'(rq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
